// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multi-cycle RV32I control FSM (master) and the datapath / ALU decoder (slave).
// Also holds the ALU operation codes carried on alu_op.
`ifndef ALU_NOP
`define ALU_NOP 2'b00
`endif
`ifndef ALU_ADD
`define ALU_ADD 2'b01
`endif
`ifndef ALU_SUB
`define ALU_SUB 2'b10
`endif
`ifndef ALU
`define ALU 2'b11
`endif

interface multicycle_control_fsm_if;
  logic [6:0]  opcode;
  logic        bcond;
  logic        halt_req;
  logic        pc_write;
  logic        pc_source;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic [1:0]  mem_to_reg;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        is_ecall;
  logic        is_halted;
  logic [31:0] retired_count;

  modport master (
    input  opcode, bcond, halt_req,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, is_ecall, is_halted, retired_count
  );

  modport slave (
    output opcode, bcond, halt_req,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, is_ecall, is_halted, retired_count
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: IF/ID/EX/MEM/WB sequencing plus ECALL halt.
// Optional retired-instruction counter built only when INSTR_COUNT_EN is defined.
`ifndef ALU_NOP
`define ALU_NOP 2'b00
`endif
`ifndef ALU_ADD
`define ALU_ADD 2'b01
`endif
`ifndef ALU_SUB
`define ALU_SUB 2'b10
`endif
`ifndef ALU
`define ALU 2'b11
`endif

module multicycle_control_fsm #(
  parameter int MEM_LATENCY = 1
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_control_fsm_if.master  bus
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;
  localparam logic [3:0] LAST_WAIT    = 4'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IF, S_ID, S_EX, S_MEM, S_WB, S_ECALL, S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait;
  logic       r_halted;
  logic       w_last;

  logic       w_pc_write;
  logic       w_pc_source;
  logic       w_i_or_d;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_mem_to_reg;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_is_ecall;

  assign w_last = (r_wait == LAST_WAIT);

  // Wait counter restarts whenever the state changes, so entry to IF/MEM always begins at 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_INIT;
      r_wait   <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait <= '0;
      else if (r_state == S_IF || r_state == S_MEM)
        r_wait <= r_wait + 4'd1;
      if (w_next == S_HALT)
        r_halted <= 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_pc_source  = 1'b0;
    w_i_or_d     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = `ALU_NOP;
    w_is_ecall   = 1'b0;
    case (r_state)
      S_INIT: w_next = S_IF;
      S_IF: begin
        w_mem_read = 1'b1;
        if (w_last) begin
          w_ir_write  = 1'b1;
          w_pc_write  = 1'b1;
          w_alu_src_b = 2'b01;
          w_alu_op    = `ALU_ADD;
          w_next      = S_ID;
        end
      end
      S_ID: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_alu_op    = `ALU_ADD;
        case (bus.opcode)
          OP_ECALL: w_next = S_ECALL;
          OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
          OP_BRANCH, OP_JAL, OP_JALR: w_next = S_EX;
          default: w_next = S_IF;
        endcase
      end
      S_EX: begin
        w_next = S_IF;
        case (bus.opcode)
          OP_ARITH: begin
            w_alu_src_a = 2'b10;
            w_alu_op    = `ALU;
            w_next      = S_WB;
          end
          OP_ARITH_IMM: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b10;
            w_alu_op    = `ALU;
            w_next      = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b10;
            w_alu_op    = `ALU;
            w_next      = S_MEM;
          end
          OP_BRANCH: begin
            w_alu_src_a = 2'b10;
            w_alu_op    = `ALU_SUB;
            w_pc_source = 1'b1;
            w_pc_write  = bus.bcond;
          end
          // rd captures the PC before this edge updates it, giving the link address
          OP_JAL: begin
            w_pc_write   = 1'b1;
            w_pc_source  = 1'b1;
            w_reg_write  = 1'b1;
            w_mem_to_reg = 2'b10;
          end
          OP_JALR: begin
            w_alu_src_a  = 2'b10;
            w_alu_src_b  = 2'b10;
            w_alu_op     = `ALU;
            w_pc_write   = 1'b1;
            w_reg_write  = 1'b1;
            w_mem_to_reg = 2'b10;
          end
          default: w_next = S_IF;
        endcase
      end
      S_MEM: begin
        w_i_or_d    = 1'b1;
        w_mem_read  = (bus.opcode == OP_LOAD);
        w_mem_write = (bus.opcode == OP_STORE);
        if (w_last)
          w_next = (bus.opcode == OP_LOAD) ? S_WB : S_IF;
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (bus.opcode == OP_LOAD) ? 2'b01 : 2'b00;
        w_next       = S_IF;
      end
      S_ECALL: begin
        w_is_ecall = 1'b1;
        w_next     = bus.halt_req ? S_HALT : S_IF;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_INIT;
    endcase
  end

  assign bus.pc_write   = w_pc_write;
  assign bus.pc_source  = w_pc_source;
  assign bus.i_or_d     = w_i_or_d;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.ir_write   = w_ir_write;
  assign bus.reg_write  = w_reg_write;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.is_ecall   = w_is_ecall;
  assign bus.is_halted  = r_halted;

`ifdef INSTR_COUNT_EN
  logic        w_retire;
  logic [31:0] r_retired;

  // Retire on any return to IF except the INIT->IF start-up transition
  assign w_retire = (w_next == S_IF) &&
                    (r_state == S_ID || r_state == S_EX || r_state == S_MEM ||
                     r_state == S_WB || r_state == S_ECALL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_retired <= '0;
    else if (w_retire)
      r_retired <= r_retired + 32'd1;
  end

  assign bus.retired_count = r_retired;
`else
  assign bus.retired_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two instances (MEM_LATENCY 1 and 3) run the same program
// against a per-instruction cycle-schedule model; honours INSTR_COUNT_EN like the design.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_EC   = 7'b1110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [1:0] A_NOP = 2'b00, A_ADD = 2'b01, A_SUB = 2'b10, A_ALU = 2'b11;

  typedef enum int {K_INIT, K_IF, K_ID, K_EX, K_MEM, K_WB, K_ECALL, K_HALT} kind_t;
  typedef struct {logic [6:0] op; logic bc; logic hr; logic rm;} ent_t;
  typedef struct {kind_t k; int idx; logic [6:0] op; logic bc; logic hr; logic rm;} phase_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_ecall;
    logic       is_halted;
  } ctl_t;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t prog[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ent_t mk(logic [6:0] op, logic bc, logic hr, logic rm);
    ent_t e;
    e.op = op; e.bc = bc; e.hr = hr; e.rm = rm;
    return e;
  endfunction

  function automatic phase_t ph(kind_t k, int i, ent_t e);
    phase_t p;
    p.k = k; p.idx = i; p.op = e.op; p.bc = e.bc; p.hr = e.hr; p.rm = e.rm;
    return p;
  endfunction

  // Control word the datapath must see in one cycle of a given instruction phase
  function automatic ctl_t exp_out(kind_t k, int idx, int lat, logic [6:0] op, logic bc);
    ctl_t c;
    c = '0;
    c.alu_op = A_NOP;
    case (k)
      K_IF: begin
        c.mem_read = 1'b1;
        if (idx == lat - 1) begin
          c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; c.alu_op = A_ADD;
        end
      end
      K_ID: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = A_ADD; end
      K_EX: begin
        if (op == OP_R) begin c.alu_src_a = 2'b10; c.alu_op = A_ALU; end
        if (op == OP_I || op == OP_LD || op == OP_ST) begin
          c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; c.alu_op = A_ALU;
        end
        if (op == OP_BR) begin
          c.alu_src_a = 2'b10; c.alu_op = A_SUB; c.pc_source = 1'b1; c.pc_write = bc;
        end
        if (op == OP_JAL) begin
          c.pc_write = 1'b1; c.pc_source = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 2'b10;
        end
        if (op == OP_JALR) begin
          c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; c.alu_op = A_ALU;
          c.pc_write = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 2'b10;
        end
      end
      K_MEM: begin
        c.i_or_d = 1'b1; c.mem_read = (op == OP_LD); c.mem_write = (op == OP_ST);
      end
      K_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = (op == OP_LD) ? 2'b01 : 2'b00; end
      K_ECALL: c.is_ecall = 1'b1;
      K_HALT:  c.is_halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic check(string nm, int lane, int cyc, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane=%0d cyc=%0d actual=%0h expected=%0h", nm, lane, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : 3;
    logic rst_n;
    bit   done = 1'b0;
    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.MEM_LATENCY(LAT)) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.master)
    );

    initial begin : lane
      phase_t      sched[$];
      phase_t      head;
      phase_t      popped;
      ent_t        e;
      ctl_t        act;
      ctl_t        exp;
      int          pidx;
      int          rst_hold;
      int          cyc;
      int          hcnt;
      int          irw_n;
      int          irw_t[8];
      int          exp_d[4];
      int unsigned ret_m;
      int unsigned ret_exp;
      pidx = 0; rst_hold = 3; cyc = 0; hcnt = 0; irw_n = 0; ret_m = 0;
      if (g == 0) exp_d = '{4, 5, 3, 3};
      else        exp_d = '{6, 9, 5, 5};
      bus.opcode = 7'h0; bus.bcond = 1'b0; bus.halt_req = 1'b0;
      rst_n = 1'b1;
      sched.push_back(ph(K_INIT, 0, mk(7'h0, 1'b0, 1'b0, 1'b0)));
      #2 rst_n = 1'b0;
      forever begin
        @(posedge clk);
        if (rst_n && sched[0].k != K_HALT) begin
          popped = sched.pop_front();
          if (popped.k == K_ECALL && popped.hr)
            sched.push_front(ph(K_HALT, 0, mk(popped.op, 1'b0, 1'b0, 1'b0)));
          else if (sched.size() == 0) begin
            if (popped.k != K_INIT) ret_m++;
            if (pidx < prog.size()) begin
              e = prog[pidx];
              pidx++;
            end else
              e = mk(OP_I, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < LAT; i++) sched.push_back(ph(K_IF, i, e));
            sched.push_back(ph(K_ID, 0, e));
            case (e.op)
              OP_R, OP_I: begin
                sched.push_back(ph(K_EX, 0, e));
                sched.push_back(ph(K_WB, 0, e));
              end
              OP_LD, OP_ST: begin
                sched.push_back(ph(K_EX, 0, e));
                for (int i = 0; i < LAT; i++) sched.push_back(ph(K_MEM, i, e));
                if (e.op == OP_LD) sched.push_back(ph(K_WB, 0, e));
              end
              OP_BR, OP_JAL, OP_JALR: sched.push_back(ph(K_EX, 0, e));
              OP_EC:   sched.push_back(ph(K_ECALL, 0, e));
              default: ;
            endcase
          end
        end
        #1;
        if (!rst_n) begin
          if (rst_hold == 0) rst_n = 1'b1;
          else rst_hold--;
        end
        head = sched[0];
        if (head.k == K_ID) bus.opcode = head.op;
        bus.bcond    = (head.k == K_EX)    ? head.bc : 1'($urandom);
        bus.halt_req = (head.k == K_ECALL) ? head.hr : 1'($urandom);

        @(negedge clk);
        cyc++;
        exp = exp_out(head.k, head.idx, LAT, head.op, bus.bcond);
        act = {bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
               bus.ir_write, bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
               bus.alu_op, bus.is_ecall, bus.is_halted};
`ifdef INSTR_COUNT_EN
        ret_exp = ret_m;
`else
        ret_exp = 0;
`endif
        check($sformatf("ctl_phase%0d", int'(head.k)), g, cyc, 64'(act), 64'(exp));
        check("retired_count", g, cyc, 64'(bus.retired_count), 64'(ret_exp));
        if (bus.ir_write && irw_n < 8) begin
          irw_t[irw_n] = cyc;
          irw_n++;
        end

        // Asynchronous reset in the middle of a store's memory access
        if (head.rm && head.k == K_MEM && head.idx == ((LAT > 1) ? 1 : 0)) begin
          rst_n = 1'b0;
          #1;
          act = {bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
                 bus.ir_write, bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                 bus.alu_op, bus.is_ecall, bus.is_halted};
          check("rst_mem_write", g, cyc, 64'(bus.mem_write), 64'(0));
          check("rst_ctl", g, cyc, 64'(act), 64'(0));
          check("rst_retired", g, cyc, 64'(bus.retired_count), 64'(0));
          sched.delete();
          sched.push_back(ph(K_INIT, 0, mk(7'h0, 1'b0, 1'b0, 1'b0)));
          ret_m    = 0;
          rst_hold = 0;
        end

        if (head.k == K_HALT) begin
          hcnt++;
          if (hcnt == 12 && !done) begin
            for (int i = 0; i < 4; i++)
              check($sformatf("instr_cycles%0d", i), g, cyc,
                    64'(irw_t[i+1] - irw_t[i]), 64'(exp_d[i]));
            check("halt_flag", g, cyc, 64'(bus.is_halted), 64'(1));
            check("halt_mem_read", g, cyc, 64'(bus.mem_read), 64'(0));
`ifdef INSTR_COUNT_EN
            check("final_retired", g, cyc, 64'(bus.retired_count), 64'(2));
`else
            check("final_retired", g, cyc, 64'(bus.retired_count), 64'(0));
`endif
            done = 1'b1;
          end
        end
      end
    end
  end

  initial begin : main
    logic [6:0] tbl[10];
    int         c;
    tbl = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_EC, OP_LUI, 7'h7f};
    prog.push_back(mk(OP_R,    1'b0, 1'b0, 1'b0));
    prog.push_back(mk(OP_LD,   1'b0, 1'b0, 1'b0));
    prog.push_back(mk(OP_BR,   1'b1, 1'b0, 1'b0));
    prog.push_back(mk(OP_BR,   1'b0, 1'b0, 1'b0));
    prog.push_back(mk(OP_JALR, 1'b0, 1'b0, 1'b0));
    prog.push_back(mk(OP_JAL,  1'b0, 1'b0, 1'b0));
    prog.push_back(mk(OP_ST,   1'b0, 1'b0, 1'b0));
    prog.push_back(mk(OP_I,    1'b0, 1'b0, 1'b0));
    prog.push_back(mk(OP_LUI,  1'b0, 1'b0, 1'b0));
    prog.push_back(mk(OP_EC,   1'b0, 1'b0, 1'b0));
    repeat (150) prog.push_back(mk(tbl[$urandom_range(0, 9)], 1'($urandom), 1'b0, 1'b0));
    prog.push_back(mk(OP_ST,   1'b0, 1'b0, 1'b1));
    prog.push_back(mk(OP_R,    1'b0, 1'b0, 1'b0));
    prog.push_back(mk(OP_LD,   1'b0, 1'b0, 1'b0));
    prog.push_back(mk(OP_EC,   1'b0, 1'b1, 1'b0));

    c = 0;
    while (c < 40000 && !(g_lane[0].done && g_lane[1].done)) begin
      @(negedge clk);
      c++;
    end
    if (!(g_lane[0].done && g_lane[1].done)) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout lanes_done=%0d%0d required=11", g_lane[0].done, g_lane[1].done);
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
